add64_seq: RTL and testbench
============================

ADD64_SEQ -- requirements
Module: add64_seq

Interface
REQ-001 SHALL have parameter NCHUNK, default 4: number of 16-bit chunks; operand width W = 16*NCHUNK.
REQ-002 SHALL have parameter CHUNK_W, default 16: width of the shared adder slice, fixed at 16.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  request valid.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 a  input  W  operand A.
REQ-008 b  input  W  operand B.
REQ-009 sub  input  1  1 = A-B, 0 = A+B.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 sum  output  W  result.
REQ-013 cout  output  1  carry out of bit W-1; for subtract, 1 = no borrow.
REQ-014 ovf  output  1  two's-complement signed overflow of the W-bit operation.

Function
REQ-015 SHALL compute the W-bit add/sub serially with one 16-bit carry-lookahead adder, one chunk per cycle, LSB chunk first.
REQ-016 FSM states SHALL be IDLE, RUN and DONE.
REQ-017 IDLE: in_ready=1; on in_valid&in_ready, latch a, b and sub, clear chunk index, set carry register to sub, and go to RUN.
REQ-018 RUN: each cycle, add chunk k of A and chunk k of (sub ? ~B : B) with carry-in = carry register; write the 16-bit result into sum chunk k; update the carry register with the slice carry-out; increment k.
REQ-019 RUN: when k = NCHUNK-1 is processed, go to DONE on the same edge; cout = final carry; ovf = (A[W-1] == B'[W-1]) & (sum[W-1] != A[W-1]), where B' is the post-inversion operand.
REQ-020 DONE: out_valid=1; sum, cout and ovf SHALL hold stable until out_valid&out_ready, then go to IDLE.
REQ-021 Latency: out_valid SHALL rise exactly NCHUNK cycles after the accepting edge (4 cycles at default).
REQ-022 in_ready SHALL be 0 in RUN and DONE; no request is accepted in the cycle the result is consumed; the next accept occurs in IDLE at the earliest.
REQ-023 a, b and sub SHALL be ignored outside the accepting edge; input changes during RUN SHALL NOT affect the result.
REQ-024 Carry wrap: the carry out of bit W-1 SHALL NOT feed any later operation; each request starts with carry-in = sub.
REQ-025 out_valid SHALL NOT depend combinationally on out_ready; in_ready SHALL NOT depend combinationally on in_valid.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, k=0, carry=0, sum=0, cout=0, ovf=0, out_valid=0; in_ready=1 once reset is released.
REQ-027 Reset asserted in RUN or DONE SHALL abort the operation without producing out_valid; the first post-reset request SHALL complete normally.

Structure
REQ-028 Shared package SHALL hold CHUNK_W, the state encodings (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the chunk-index width derivation.
REQ-029 The 16-bit adder SHALL be a single sub-module, cla_16bit: combinational, built from the team's 4-bit/16-bit carry-lookahead units, with ports a, b, ci, s, co; instantiated once.
REQ-030 Operand shift/select SHALL use the index k on latched registers; no W-bit combinational adder is permitted.

Verification
REQ-031 Add: a=64'h0000_0000_0000_FFFF, b=1, sub=0 -> after 4 cycles sum=64'h0000_0000_0001_0000, cout=0, ovf=0 (chunk carry propagates).
REQ-032 Full carry ripple: a=64'hFFFF_FFFF_FFFF_FFFF, b=1, sub=0 -> sum=0, cout=1, ovf=0.
REQ-033 Signed overflow: a=64'h7FFF_FFFF_FFFF_FFFF, b=1, sub=0 -> sum=64'h8000_0000_0000_0000, ovf=1, cout=0; sub case a=64'h8000_0000_0000_0000, b=1, sub=1 -> sum=64'h7FFF_FFFF_FFFF_FFFF, ovf=1, cout=1.
REQ-034 Backpressure: hold out_ready=0 for 5 cycles after out_valid -> sum stable, in_ready=0 throughout; after out_ready=1 the block is in IDLE on the next cycle and accepts a=5, b=3, sub=1 -> sum=2, cout=1.
REQ-035 Reset mid-RUN: assert rst_n=0 at cycle 2 of an operation -> out_valid=0 and sum=0 immediately; after release, a=10, b=20, sub=0 -> sum=30 after 4 cycles.
REQ-036 Input change: change a and b during RUN -> result equals the latched operands.

Source files
------------

// File: rtl/add64_seq_pkg.sv
// Shared definitions for the chunk-serial add/sub unit: slice width,
// FSM state encoding and the chunk-index width helper.
package add64_seq_pkg;

  localparam int CHUNK_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // A single-chunk configuration still needs a 1-bit index register.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cla_16bit.sv
// 16-bit carry-lookahead adder: four 4-bit lookahead groups tied together
// by a second level of the same 4-bit lookahead logic. Purely combinational.
module cla_16bit
  import add64_seq_pkg::*;
(
  input  logic [CHUNK_W-1:0] a,
  input  logic [CHUNK_W-1:0] b,
  input  logic               ci,
  output logic [CHUNK_W-1:0] s,
  output logic               co
);

  localparam int NGRP = CHUNK_W / 4;

  // Carries into each of four positions, given propagate/generate and carry-in.
  function automatic logic [3:0] cla4_carry(input logic [3:0] p,
                                            input logic [3:0] g,
                                            input logic       c0);
    logic [3:0] c;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    return c;
  endfunction

  // Group propagate (bit 1) and group generate (bit 0) of four positions.
  function automatic logic [1:0] cla4_pg(input logic [3:0] p,
                                         input logic [3:0] g);
    logic grp_p;
    logic grp_g;
    grp_p = &p;
    grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    return {grp_p, grp_g};
  endfunction

  logic [CHUNK_W-1:0] bit_p;
  logic [CHUNK_W-1:0] bit_g;
  logic [CHUNK_W-1:0] bit_c;
  logic [NGRP-1:0]    grp_p;
  logic [NGRP-1:0]    grp_g;
  logic [NGRP-1:0]    grp_c;
  logic [1:0]         top_pg;

  assign bit_p = a ^ b;
  assign bit_g = a & b;

  always_comb begin
    grp_p = '0;
    grp_g = '0;
    for (int j = 0; j < NGRP; j++) begin
      {grp_p[j], grp_g[j]} = cla4_pg(bit_p[4*j +: 4], bit_g[4*j +: 4]);
    end
  end

  assign grp_c  = cla4_carry(grp_p, grp_g, ci);
  assign top_pg = cla4_pg(grp_p, grp_g);
  assign co     = top_pg[0] | (top_pg[1] & ci);

  always_comb begin
    bit_c = '0;
    for (int j = 0; j < NGRP; j++) begin
      bit_c[4*j +: 4] = cla4_carry(bit_p[4*j +: 4], bit_g[4*j +: 4], grp_c[j]);
    end
  end

  assign s = bit_p ^ bit_c;

endmodule

// File: rtl/add64_seq.sv
// Chunk-serial W-bit adder/subtractor: one shared 16-bit CLA slice processes
// one chunk per cycle, LSB first, with a valid/ready handshake on both sides.
module add64_seq
  import add64_seq_pkg::*;
#(
  parameter  int NCHUNK  = 4,
  parameter  int CHUNK_W = 16,
  localparam int W       = 16 * NCHUNK
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int KW = idx_w(NCHUNK);

  state_t         state;
  state_t         state_nxt;
  logic [KW-1:0]  k;
  logic           carry;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [W-1:0]   sum_q;
  logic           cout_q;
  logic           ovf_q;
  logic           accept;
  logic           step;
  logic           last;

  logic [CHUNK_W-1:0] a_chunk;
  logic [CHUNK_W-1:0] b_chunk;
  logic [CHUNK_W-1:0] s_chunk;
  logic               co_chunk;

  assign last = (k == KW'(NCHUNK - 1));

  // Handshake outputs decode from state only, never from in_valid/out_ready.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // B is stored already inverted for subtract, so the slice only ever adds.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a;
      b_q <= sub ? ~b : b;
    end
  end

  assign a_chunk = a_q[CHUNK_W*k +: CHUNK_W];
  assign b_chunk = b_q[CHUNK_W*k +: CHUNK_W];

  cla_16bit u_cla (
    .a  (a_chunk),
    .b  (b_chunk),
    .ci (carry),
    .s  (s_chunk),
    .co (co_chunk)
  );

  // Carry-in of every request is reloaded from sub, so no carry leaks across requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k      <= '0;
      carry  <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      k     <= '0;
      carry <= sub;
    end else if (step) begin
      sum_q[CHUNK_W*k +: CHUNK_W] <= s_chunk;
      carry <= co_chunk;
      k     <= k + KW'(1);
      if (last) begin
        cout_q <= co_chunk;
        ovf_q  <= (a_q[W-1] == b_q[W-1]) & (s_chunk[CHUNK_W-1] != a_q[W-1]);
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_add64_seq.sv
// Self-checking bench for add64_seq: directed vector table, handshake and
// reset corner sequences, and random operations against an arithmetic model.
module tb_add64_seq;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  add64_seq #(.NCHUNK(4), .CHUNK_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Reference: plain unsigned/signed arithmetic on the full-width operands.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic ms);
    logic [W:0]   t;
    logic [W-1:0] r;
    logic         c;
    logic         o;
    if (ms) t = {1'b0, ma} - {1'b0, mb};
    else    t = {1'b0, ma} + {1'b0, mb};
    r = t[W-1:0];
    c = ms ? (ma >= mb) : t[W];
    if (ms) o = (ma[W-1] != mb[W-1]) && (r[W-1] != ma[W-1]);
    else    o = (ma[W-1] == mb[W-1]) && (r[W-1] != ma[W-1]);
    return {o, c, r};
  endfunction

  // Returns at the falling edge just after the accepting edge.
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_b, input logic ts);
    @(negedge clk);
    a = ta; b = tb_b; sub = ts; in_valid = 1'b1;
    chk("in_ready_idle", W'(in_ready), W'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("in_ready_run", W'(in_ready), W'(0));
  endtask

  task automatic wait_result(input string name, input logic [W-1:0] es, input logic ec,
                             input logic eo, input bit scramble);
    int cyc = 0;
    while (!out_valid && cyc < 16) begin
      if (scramble) begin
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; sub = 1'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    chk({name, "_latency"}, W'(cyc), W'(4));
    chk({name, "_sum"}, sum, es);
    chk({name, "_cout"}, W'(cout), W'(ec));
    chk({name, "_ovf"}, W'(ovf), W'(eo));
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_cleared", W'(out_valid), W'(0));
    chk("in_ready_after_consume", W'(in_ready), W'(1));
  endtask

  task automatic op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_b,
                    input logic ts, input bit scramble);
    logic [W+1:0] m;
    m = model(ta, tb_b, ts);
    start_op(ta, tb_b, ts);
    wait_result(name, m[W-1:0], m[W], m[W+1], scramble);
    consume();
  endtask

  initial begin
    logic [W-1:0] held;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    bit           seen;

    tbl[0] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
    tbl[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0,                   1'b1, 1'b0};
    tbl[2] = '{64'h0,                   64'h0, 1'b0, 64'h0,                   1'b0, 1'b0};
    tbl[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    tbl[4] = '{64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    tbl[5] = '{64'h5,                   64'h3, 1'b1, 64'h2,                   1'b1, 1'b0};
    tbl[6] = '{64'h3,                   64'h5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    tbl[7] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1};
    tbl[8] = '{64'h0,                   64'h0, 1'b1, 64'h0,                   1'b1, 1'b0};

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_sum", sum, W'(0));
    chk("rst_cout", W'(cout), W'(0));
    chk("rst_ovf", W'(ovf), W'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", W'(in_ready), W'(1));

    // Directed vectors
    for (int i = 0; i < 9; i++) begin
      start_op(tbl[i].a, tbl[i].b, tbl[i].sub);
      wait_result($sformatf("vec%0d", i), tbl[i].sum, tbl[i].cout, tbl[i].ovf, 1'b0);
      consume();
    end

    // Backpressure: result held while out_ready stays low
    start_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0);
    wait_result("bp", 64'h2222_2222_2222_2211, 1'b0, 1'b0, 1'b0);
    held = sum;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_sum_stable", sum, held);
      chk("bp_in_ready_low", W'(in_ready), W'(0));
      chk("bp_out_valid_high", W'(out_valid), W'(1));
    end
    consume();
    start_op(64'h5, 64'h3, 1'b1);
    wait_result("bp_next", 64'h2, 1'b1, 1'b0, 1'b0);
    consume();

    // Reset during RUN aborts the operation
    start_op(64'hAAAA_0000_5555_0000, 64'h1111_2222_3333_4444, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", W'(out_valid), W'(0));
    chk("abort_sum", sum, W'(0));
    chk("abort_cout", W'(cout), W'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_out_valid", W'(seen), W'(0));
    start_op(64'd10, 64'd20, 1'b0);
    wait_result("post_abort", 64'd30, 1'b0, 1'b0, 1'b0);
    consume();

    // Random operations, half of them with operands scrambled during RUN
    for (int i = 0; i < 40; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i % 8 == 3) rb = ~ra;
      if (i % 8 == 5) rb = ra;
      op($sformatf("rnd%0d", i), ra, rb, 1'($urandom), (i % 2) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "simulation time limit");
  end

endmodule
